// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle between the reservation station and the ALU execution unit.
// Valid-only handshake: alu_en marks a valid issue each cycle; alu_rdy marks a valid result.
interface alu_exec_unit_if;
  logic        alu_en;
  logic [4:0]  alu_type;
  logic [31:0] alu_data_j;
  logic [31:0] alu_data_k;
  logic [31:0] alu_imm;
  logic [31:0] alu_rob_id_in;
  logic        alu_rdy;
  logic [31:0] alu_rob_id_out;
  logic [31:0] alu_result;

  modport master (
    output alu_en, alu_type, alu_data_j, alu_data_k, alu_imm, alu_rob_id_in,
    input  alu_rdy, alu_rob_id_out, alu_result
  );

  modport slave (
    input  alu_en, alu_type, alu_data_j, alu_data_k, alu_imm, alu_rob_id_in,
    output alu_rdy, alu_rob_id_out, alu_result
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Two-stage RV32I integer execution unit: stage 1 captures the issued op, stage 2
// computes and presents a one-cycle result pulse. Flush squashes both stages.
module alu_exec_unit #(
  parameter int ROB_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  alu_exec_unit_if.slave   alu
);

  logic              r_s1_valid;
  logic [3:0]        r_s1_op;
  logic [31:0]       r_s1_a;
  logic [31:0]       r_s1_b;
  logic [ROB_W-1:0]  r_s1_rob_lo;
  logic [31:ROB_W]   r_s1_rob_hi;
  logic              r_rdy;
  logic [31:0]       r_result;
  logic [31:0]       r_rob_out;

  logic [31:0]       w_b_sel;
  logic [4:0]        w_shamt;
  logic              w_lt_s;
  logic              w_lt_u;
  logic [31:0]       w_sra;
  logic [31:0]       w_result;

  // alu_type[4] only steers the B mux; it is not part of the stored opcode.
  assign w_b_sel = alu.alu_type[4] ? alu.alu_imm : alu.alu_data_k;
  assign w_shamt = r_s1_b[4:0];
  assign w_lt_s  = $signed(r_s1_a) < $signed(r_s1_b);
  assign w_lt_u  = r_s1_a < r_s1_b;
  assign w_sra   = $unsigned($signed(r_s1_a) >>> w_shamt);

  always_comb begin
    w_result = 32'd0;
    case (r_s1_op)
      4'd0:    w_result = r_s1_a + r_s1_b;
      4'd1:    w_result = r_s1_a - r_s1_b;
      4'd2:    w_result = r_s1_a << w_shamt;
      4'd3:    w_result = {31'd0, w_lt_s};
      4'd4:    w_result = {31'd0, w_lt_u};
      4'd5:    w_result = r_s1_a ^ r_s1_b;
      4'd6:    w_result = r_s1_a >> w_shamt;
      4'd7:    w_result = w_sra;
      4'd8:    w_result = r_s1_a | r_s1_b;
      4'd9:    w_result = r_s1_a & r_s1_b;
      4'd10:   w_result = {31'd0, r_s1_a == r_s1_b};
      4'd11:   w_result = {31'd0, r_s1_a != r_s1_b};
      4'd12:   w_result = {31'd0, ~w_lt_s};
      4'd13:   w_result = {31'd0, ~w_lt_u};
      4'd14:   w_result = r_s1_b;
      default: w_result = 32'd0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= 4'd0;
      r_s1_a      <= 32'd0;
      r_s1_b      <= 32'd0;
      r_s1_rob_lo <= '0;
      r_s1_rob_hi <= '0;
      r_rdy       <= 1'b0;
      r_result    <= 32'd0;
      r_rob_out   <= 32'd0;
    end else if (rdy_in) begin
      if (flush) begin
        // Data registers keep stale contents; only the valid bits matter.
        r_s1_valid <= 1'b0;
        r_rdy      <= 1'b0;
      end else begin
        r_s1_valid <= alu.alu_en;
        if (alu.alu_en) begin
          r_s1_op     <= alu.alu_type[3:0];
          r_s1_a      <= alu.alu_data_j;
          r_s1_b      <= w_b_sel;
          r_s1_rob_lo <= alu.alu_rob_id_in[ROB_W-1:0];
          r_s1_rob_hi <= alu.alu_rob_id_in[31:ROB_W];
        end
        r_rdy <= r_s1_valid;
        if (r_s1_valid) begin
          r_result  <= w_result;
          r_rob_out <= {r_s1_rob_hi, r_s1_rob_lo};
        end
      end
    end
  end

  assign alu.alu_rdy        = r_rdy;
  assign alu.alu_result     = r_result;
  assign alu.alu_rob_id_out = r_rob_out;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: reset, single op, back-to-back streams,
// opcode edge cases, flush, stall and asynchronous reset.
module tb_alu_exec_unit;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic flush;

  alu_exec_unit_if alu ();

  alu_exec_unit #(.ROB_W(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .alu    (alu.slave)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  t;
    logic [31:0] a;
    logic [31:0] k;
    logic [31:0] imm;
    logic [31:0] rob;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_rob_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic en, input logic [4:0] t, input logic [31:0] a,
                       input logic [31:0] k, input logic [31:0] imm, input logic [31:0] rob);
    alu.alu_en        = en;
    alu.alu_type      = t;
    alu.alu_data_j    = a;
    alu.alu_data_k    = k;
    alu.alu_imm       = imm;
    alu.alu_rob_id_in = rob;
  endtask

  task automatic add_vec(input logic [4:0] t, input logic [31:0] a, input logic [31:0] k,
                         input logic [31:0] imm, input logic [31:0] rob, input logic [31:0] exp);
    vec_t v;
    v.t = t; v.a = a; v.k = k; v.imm = imm; v.rob = rob; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Issues every queued vector back-to-back and expects one pulse per cycle in order.
  task automatic run_vectors(input string tag);
    int n;
    n = vecs.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        drive(1'b1, vecs[i].t, vecs[i].a, vecs[i].k, vecs[i].imm, vecs[i].rob);
        exp_q.push_back(vecs[i].exp);
        exp_rob_q.push_back(vecs[i].rob);
      end else begin
        drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      end
      step();
      if (i > 0) begin
        check($sformatf("%s_rdy%0d", tag, i - 1), {31'd0, alu.alu_rdy}, 32'd1);
        check($sformatf("%s_res%0d", tag, i - 1), alu.alu_result, exp_q.pop_front());
        check($sformatf("%s_rob%0d", tag, i - 1), alu.alu_rob_id_out, exp_rob_q.pop_front());
      end
    end
    step();
    check({tag, "_idle"}, {31'd0, alu.alu_rdy}, 32'd0);
    vecs.delete();
  endtask

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    flush  = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);

    // Reset and idle
    step();
    step();
    check("rst_rdy", {31'd0, alu.alu_rdy}, 32'd0);
    check("rst_res", alu.alu_result, 32'd0);
    check("rst_rob", alu.alu_rob_id_out, 32'd0);
    rst_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_rdy", {31'd0, alu.alu_rdy}, 32'd0);
      check("idle_res", alu.alu_result, 32'd0);
      check("idle_rob", alu.alu_rob_id_out, 32'd0);
    end

    // Single ADD: pulse after the second edge, then drops
    drive(1'b1, 5'd0, 32'd5, 32'd7, 32'd99, 32'd3);
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    check("add_early", {31'd0, alu.alu_rdy}, 32'd0);
    step();
    check("add_rdy", {31'd0, alu.alu_rdy}, 32'd1);
    check("add_res", alu.alu_result, 32'd12);
    check("add_rob", alu.alu_rob_id_out, 32'd3);
    step();
    check("add_drop", {31'd0, alu.alu_rdy}, 32'd0);
    check("add_hold", alu.alu_result, 32'd12);
    check("add_hold_rob", alu.alu_rob_id_out, 32'd3);

    // Back-to-back stream
    add_vec(5'h01, 32'h0000_0000, 32'h0000_0001, 32'h0000_0055, 32'd10, 32'hFFFF_FFFF);
    add_vec(5'h17, 32'h8000_0000, 32'h0000_00FF, 32'h0000_0004, 32'd11, 32'hF800_0000);
    add_vec(5'h04, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'd12, 32'd1);
    add_vec(5'h03, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'd13, 32'd0);
    run_vectors("b2b");

    // Compare and shift edges
    add_vec(5'h0A, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 32'd1, 32'd1);
    add_vec(5'h0C, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'd2, 32'd0);
    add_vec(5'h02, 32'h0000_0001, 32'h0000_0021, 32'h0000_0000, 32'd4, 32'd2);
    add_vec(5'h1E, 32'hAAAA_AAAA, 32'h0000_0000, 32'h1234_5000, 32'd5, 32'h1234_5000);
    run_vectors("edge");

    // Remaining opcodes, immediate forms and upper ROB-id passthrough
    add_vec(5'h05, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'hABCD_0006, 32'hFF00_FF00);
    add_vec(5'h06, 32'h8000_0000, 32'h0000_0024, 32'h0, 32'h0000_0017, 32'h0800_0000);
    add_vec(5'h08, 32'h1200_0034, 32'h0056_7800, 32'h0, 32'h8000_0008, 32'h1256_7834);
    add_vec(5'h19, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0F0F, 32'h0000_0009, 32'h0000_0608);
    add_vec(5'h0B, 32'h0000_0001, 32'h0000_0002, 32'h0, 32'h0000_000A, 32'd1);
    add_vec(5'h0D, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 32'h0000_000B, 32'd1);
    add_vec(5'h0F, 32'h1234_5678, 32'h1111_1111, 32'h0, 32'h0000_000C, 32'd0);
    add_vec(5'h10, 32'h0000_0010, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_000D, 32'h0000_000F);
    add_vec(5'h03, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 32'h0000_000E, 32'd1);
    run_vectors("ops");

    // Flush squashes the op in stage 1 and the op issued alongside the flush
    drive(1'b1, 5'd0, 32'd1, 32'd1, 32'd0, 32'd20);
    step();
    drive(1'b1, 5'd0, 32'd2, 32'd2, 32'd0, 32'd21);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_n1", {31'd0, alu.alu_rdy}, 32'd0);
    drive(1'b1, 5'd1, 32'd50, 32'd8, 32'd0, 32'd22);
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    check("flush_n2", {31'd0, alu.alu_rdy}, 32'd0);
    step();
    check("flush_after_rdy", {31'd0, alu.alu_rdy}, 32'd1);
    check("flush_after_res", alu.alu_result, 32'd42);
    check("flush_after_rob", alu.alu_rob_id_out, 32'd22);
    step();
    check("flush_after_drop", {31'd0, alu.alu_rdy}, 32'd0);

    // Stall: issue, freeze three cycles with noisy inputs, then one pulse
    drive(1'b1, 5'd0, 32'd100, 32'd23, 32'd0, 32'd7);
    step();
    rdy_in = 1'b0;
    flush  = 1'b1;
    drive(1'b1, 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd15);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_rdy", {31'd0, alu.alu_rdy}, 32'd0);
      check("stall_res", alu.alu_result, 32'd42);
      check("stall_rob", alu.alu_rob_id_out, 32'd22);
    end
    rdy_in = 1'b1;
    flush  = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    step();
    check("stall_out_rdy", {31'd0, alu.alu_rdy}, 32'd1);
    check("stall_out_res", alu.alu_result, 32'd123);
    check("stall_out_rob", alu.alu_rob_id_out, 32'd7);
    step();
    check("stall_once", {31'd0, alu.alu_rdy}, 32'd0);

    // Asynchronous reset while a pulse is showing
    drive(1'b1, 5'd8, 32'h00F0, 32'h000F, 32'd0, 32'd9);
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    step();
    check("arst_pre_rdy", {31'd0, alu.alu_rdy}, 32'd1);
    check("arst_pre_res", alu.alu_result, 32'h00FF);
    #2;
    rst_in = 1'b0;
    #1;
    check("arst_rdy", {31'd0, alu.alu_rdy}, 32'd0);
    check("arst_res", alu.alu_result, 32'd0);
    check("arst_rob", alu.alu_rob_id_out, 32'd0);
    step();
    rst_in = 1'b1;
    step();
    step();
    check("arst_quiet", {31'd0, alu.alu_rdy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution responder on the reservation station's ALU issue interface.
- Accepts at most one ready operation per cycle: type, two operands, immediate and ROB id.
- Computes the RV32I integer result in a 2-stage pipeline.
- Returns a result/ROB-id pulse that the station forwards to the ROB and broadcasts to the RS and LSB. Flush squashes all in-flight work.

Parameters:
- ROB_W, 4, significant ROB-id bits; upper id bits are carried through unchanged.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global enable; low = full freeze of all state
- flush  in  1  squash all in-flight operations
- alu_en  in  1  issue valid
- alu_type  in  5  operation code
- alu_data_j  in  32  operand A
- alu_data_k  in  32  operand B (register)
- alu_imm  in  32  immediate
- alu_rob_id_in  in  32  ROB id of the issued operation
- alu_rdy  out  1  result valid, one-cycle pulse per operation
- alu_rob_id_out  out  32  ROB id of the result
- alu_result  out  32  result value

Behaviour:
- Reset (rst_in low, asynchronous): both stage-valid bits, alu_rdy, alu_rob_id_out and alu_result go to 0. All pipeline data registers are cleared. Reset can occur mid-operation and drops any in-flight op.
- No backpressure: the RS issues whenever it has a ready entry. The unit accepts one op per cycle, every cycle.
- Stage 1 (capture), on a clock edge with rdy_in=1, flush=0:
  - s1_valid <= alu_en.
  - If alu_en=1, latch type, A, rob_id, and B: B = alu_imm when alu_type[4]=1, else alu_data_k.
- Stage 2 (execute), on a clock edge with rdy_in=1, flush=0:
  - alu_rdy <= s1_valid.
  - If s1_valid=1, alu_result <= f(op, A, B) and alu_rob_id_out <= s1 rob_id.
  - If s1_valid=0, alu_result and alu_rob_id_out hold their previous values.
- Latency: an op issued at edge N appears with alu_rdy=1 during the cycle after edge N+1. Throughput is 1 op/cycle. Back-to-back ops produce back-to-back pulses in issue order.
- Op = alu_type[3:0]; alu_type[4] selects the immediate only.
  - 0 ADD: A+B, mod 2^32.
  - 1 SUB: A-B, mod 2^32.
  - 2 SLL: A << B[4:0].
  - 3 SLT: signed A<B ? 1 : 0.
  - 4 SLTU: unsigned A<B ? 1 : 0.
  - 5 XOR.
  - 6 SRL: logical shift by B[4:0].
  - 7 SRA: arithmetic shift by B[4:0].
  - 8 OR.
  - 9 AND.
  - 10 EQ: A==B ? 1 : 0.
  - 11 NE.
  - 12 GE: signed A>=B ? 1 : 0.
  - 13 GEU: unsigned A>=B ? 1 : 0.
  - 14 PASSB: result = B (LUI).
  - 15 reserved: result = 0, alu_rdy still pulses.
- Shift amounts use only B[4:0]; upper bits are ignored.
- flush=1 at an edge (with rdy_in=1): s1_valid <= 0 and alu_rdy <= 0, regardless of alu_en. An op issued in the same cycle as flush is discarded. Data registers may keep stale values.
- rdy_in=0: no register changes, and alu_en is ignored. The RS also freezes, so no issue is lost. flush is also ignored while rdy_in=0.
- Priority: reset > rdy_in=0 > flush > normal.
- alu_rob_id bits above ROB_W pass through unchanged.

Test Plan:
- Reset/idle: hold rst_in low, then release with alu_en=0 for 5 cycles -> alu_rdy=0, alu_result=0, alu_rob_id_out=0 throughout.
- Single ADD: issue type=0, A=5, B=7, rob_id=3 at edge N -> after edge N+1: alu_rdy=1, result=12, rob_id_out=3. Next cycle alu_rdy=0.
- Back-to-back, one per cycle:
  - SUB A=0, B=1 -> 0xFFFFFFFF.
  - SRA A=0x80000000, imm=4 (type=0x17) -> 0xF8000000.
  - SLTU A=1, B=0xFFFFFFFF -> 1.
  - SLT with the same operands -> 0.
  - Expect 4 consecutive pulses in issue order with those values and matching rob_ids.
- Compare and shift edges:
  - EQ with A=B=0xDEADBEEF -> 1.
  - GE A=0xFFFFFFFF, B=0 -> 0.
  - SLL A=1, B=0x21 -> 2 (only B[4:0]=1 used).
  - PASSB imm=0x12345000 -> 0x12345000.
- Flush: issue ops at edges N and N+1 and assert flush at edge N+1 -> no alu_rdy pulse for either op. An op issued at N+2 returns normally after N+3.
- Stall and async reset:
  - Issue at N, then rdy_in=0 for 3 cycles -> pipeline state and outputs frozen. After rdy_in returns to 1, exactly one pulse with the correct result.
  - Drop rst_in between clock edges while alu_rdy=1 -> outputs clear immediately, without waiting for a clock edge.
